// File: rtl/playback_scheduler.sv
// Song playback sequencer: picks a song from the address table, primes the audio FIFO
// with one SD block, then tops it up one block per programmable-empty request until the end.
module playback_scheduler #(
    parameter int                      NUM_SONGS   = 4,
    parameter int                      BLOCK_BYTES = 512,
    parameter logic [NUM_SONGS*32-1:0] SONG_STARTS = '0,
    parameter logic [NUM_SONGS*32-1:0] SONG_ENDS   = '0,
    parameter int                      TIMEOUT     = 2_000_000,
    localparam int                     SW          = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          select_in,
    input  logic          up_in,
    input  logic          down_in,
    input  logic          abort_in,
    input  logic          sd_valid_in,
    input  logic          sd_done_in,
    input  logic          fifo_full_in,
    input  logic          fifo_prog_empty_in,
    output logic          read_start_out,
    output logic [31:0]   read_addr_out,
    output logic          fifo_wr_en_out,
    output logic          stream_ready_out,
    output logic [SW-1:0] song_num_out,
    output logic          playing_out,
    output logic          song_done_out,
    output logic [2:0]    err_out
);
    localparam int CW = $clog2(BLOCK_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, READ, DRAIN, ABORT_WAIT} state_t;

    state_t        state_q;
    logic          sel_q, up_q, dn_q;
    logic [SW-1:0] song_q;
    logic [31:0]   addr_q, end_q, raddr_q;
    logic          rs_q, sr_q, done_q;
    logic [2:0]    err_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmo_q;

    logic          sel_e, up_e, dn_e, busy, accept, last_blk, short_blk, tmo_hit;
    logic [32:0]   next_sum;
    logic [CW-1:0] cnt_d;
    logic [31:0]   start_w, stop_w;

    assign sel_e     = select_in & ~sel_q;
    assign up_e      = up_in & ~up_q;
    assign dn_e      = down_in & ~dn_q;
    assign start_w   = SONG_STARTS[32*int'(song_q) +: 32];
    assign stop_w    = SONG_ENDS[32*int'(song_q) +: 32];
    assign busy      = (state_q == PRIME) || (state_q == READ) || (state_q == ABORT_WAIT);
    assign accept    = sd_valid_in & ~fifo_full_in & busy;
    assign cnt_d     = cnt_q + CW'(accept);
    assign short_blk = sd_done_in && (32'(cnt_d) != 32'(BLOCK_BYTES));
    assign tmo_hit   = busy && (tmo_q == TW'(TIMEOUT - 1));
    // A carry out of the 32-bit sum counts as past the end of the song.
    assign next_sum  = {1'b0, addr_q} + 33'(BLOCK_BYTES);
    assign last_blk  = next_sum[32] || (next_sum[31:0] >= end_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            song_q  <= '0;
            addr_q  <= '0;
            end_q   <= '0;
            raddr_q <= '0;
            rs_q    <= 1'b0;
            sr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            sel_q  <= select_in;
            up_q   <= up_in;
            dn_q   <= down_in;
            rs_q   <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= (busy && !sd_done_in) ? cnt_d : '0;
            if (busy) tmo_q <= tmo_q + 1'b1;
            if (busy && sd_valid_in && fifo_full_in) err_q[0] <= 1'b1;
            if (busy && short_blk) err_q[1] <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (up_e && !dn_e)
                        song_q <= (song_q == SW'(NUM_SONGS - 1)) ? '0 : song_q + 1'b1;
                    else if (dn_e && !up_e)
                        song_q <= (song_q == '0) ? SW'(NUM_SONGS - 1) : song_q - 1'b1;
                    if (sel_e) begin
                        err_q  <= '0;
                        addr_q <= start_w;
                        end_q  <= stop_w;
                        if (start_w >= stop_w) begin
                            done_q <= 1'b1;
                        end else begin
                            rs_q    <= 1'b1;
                            raddr_q <= start_w;
                            tmo_q   <= '0;
                            state_q <= PRIME;
                        end
                    end
                end
                PRIME, READ: begin
                    // A completion landing with abort is still accounted before stopping.
                    if (sd_done_in) begin
                        addr_q <= next_sum[31:0];
                        sr_q   <= !abort_in;
                        if (abort_in)      state_q <= IDLE;
                        else if (last_blk) state_q <= DRAIN;
                        else               state_q <= STREAM;
                    end else if (tmo_hit) begin
                        err_q[2] <= 1'b1;
                        sr_q     <= 1'b0;
                        state_q  <= IDLE;
                    end else if (abort_in) begin
                        sr_q    <= 1'b0;
                        state_q <= ABORT_WAIT;
                    end
                end
                STREAM: begin
                    if (abort_in) begin
                        sr_q    <= 1'b0;
                        state_q <= IDLE;
                    end else if (fifo_prog_empty_in) begin
                        rs_q    <= 1'b1;
                        raddr_q <= addr_q;
                        tmo_q   <= '0;
                        state_q <= READ;
                    end
                end
                DRAIN: begin
                    if (abort_in) begin
                        sr_q    <= 1'b0;
                        state_q <= IDLE;
                    end else if (fifo_prog_empty_in) begin
                        sr_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ABORT_WAIT: begin
                    if (sd_done_in) begin
                        state_q <= IDLE;
                    end else if (tmo_hit) begin
                        err_q[2] <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_start_out   = rs_q;
    assign read_addr_out    = raddr_q;
    assign fifo_wr_en_out   = accept;
    assign stream_ready_out = sr_q;
    assign song_num_out     = song_q;
    assign playing_out      = (state_q != IDLE);
    assign song_done_out    = done_q;
    assign err_out          = err_q;
endmodule
